// File: rtl/seg_pkg.sv
// Package: seg_pkg
// Shared constants for the 7-segment display datapath.
//   DIGITS_DEF : default digit count of the display
//   SEL_W      : digit-select width for the default digit count
//   SEG_OFF    : active-low cathode word with every segment and dp off
//   SEG_0..F   : hex glyphs, active-high, bit order {a,b,c,d,e,f,g}
// Polarity is applied only by the consumer that drives the cathodes.
package seg_pkg;

    localparam int DIGITS_DEF = 8;
    localparam int SEL_W      = 3;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

endpackage

// File: rtl/hex_to_7seg.sv
// Module: hex_to_7seg
// Combinational hex digit to 7-segment glyph decoder.
//   nib   in  4  hex digit
//   glyph out 7  active-high segments {a,b,c,d,e,f,g}
// Letters b and d are lowercase so they cannot be confused with 8 and 0.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_0;
        case (nib)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg_data_pipe.sv
// Module: seg_data_pipe
// Holds the value shown on the multiplexed 7-segment display, selects the nibble
// for the digit the anode scanner currently drives, decodes it and registers the
// cathodes. New values are only adopted at a frame boundary (digit index wrapping
// from the last digit to 0), so a single scan frame never mixes two values.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   seg_sel    in   digit index from the scanner (asynchronous to clk)
//   data_in    in   value to display, nibble i -> digit i
//   dp_in      in   decimal points, bit i -> digit i, 1 = lit
//   data_vld   in   one-clk strobe capturing data_in/dp_in as pending value
//   seg_n      out  registered cathodes {a,b,c,d,e,f,g,dp}
//   pend       out  a captured value waits for the next frame boundary
//   frame_sot  out  one-clk pulse when the display register loads
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero nibble (digit 0 always shown).
module seg_data_pipe
    import seg_pkg::*;
#(
    parameter int DIGITS         = DIGITS_DEF,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(DIGITS)-1:0]  seg_sel,
    input  logic [4*DIGITS-1:0]        data_in,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic                       data_vld,
    output logic [7:0]                 seg_n,
    output logic                       pend,
    output logic                       frame_sot
);

    localparam int SW = $clog2(DIGITS);
    localparam int DW = 4 * DIGITS;
    localparam logic [7:0] SEG_RESET = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

    logic [SW-1:0]        s1, s2, s3, sel_q;
    logic                 sel_stable;
    logic                 boundary;
    logic [DW+DIGITS-1:0] pend_reg;
    logic [DW+DIGITS-1:0] disp;
    logic [DW-1:0]        disp_data;
    logic [DIGITS-1:0]    disp_dp;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic [6:0]           glyph;
    logic                 blank;
    logic [7:0]           seg_on;
    logic [7:0]           seg_next;

    // seg_sel bits may land in different cycles; only a value seen on two
    // consecutive samples (s2 == s3) is allowed into sel_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            sel_q <= '0;
        end else begin
            s1 <= seg_sel;
            s2 <= s1;
            s3 <= s2;
            if (sel_stable) begin
                sel_q <= s2;
            end
        end
    end

    assign sel_stable = (s2 == s3);
    assign boundary   = sel_stable && (sel_q == SW'(DIGITS - 1)) && (s2 == '0);

    // A strobe on the boundary cycle still writes pend_reg, so the display
    // takes the older pending value and the new one waits a full frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg  <= '0;
            disp      <= '0;
            pend      <= 1'b0;
            frame_sot <= 1'b0;
        end else begin
            frame_sot <= 1'b0;
            if (boundary && pend) begin
                disp      <= pend_reg;
                frame_sot <= 1'b1;
            end
            if (data_vld) begin
                pend_reg <= {dp_in, data_in};
                pend     <= 1'b1;
            end else if (boundary) begin
                pend     <= 1'b0;
            end
        end
    end

    assign disp_data = disp[DW-1:0];
    assign disp_dp   = disp[DW+DIGITS-1:DW];
    assign cur_nib   = disp_data[4*int'(sel_q) +: 4];
    assign cur_dp    = disp_dp[sel_q];

    hex_to_7seg u_hex_to_7seg (
        .nib   (cur_nib),
        .glyph (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it are zero.
    always_comb begin
        blank = 1'b0;
        if (sel_q != '0) begin
            blank = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if ((i >= int'(sel_q)) && (disp_data[4*i +: 4] != 4'h0)) begin
                    blank = 1'b0;
                end
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_on   = blank ? 8'h00 : {glyph, cur_dp};
    assign seg_next = SEG_ACTIVE_LOW ? ~seg_on : seg_on;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_n <= SEG_RESET;
        end else begin
            seg_n <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_data_pipe.sv
// Testbench: tb_seg_data_pipe
// Directed checks of seg_data_pipe: reset, display latency, frame-boundary
// loading, last-strobe-wins, boundary/strobe collision, skewed select
// filtering, non-wrap skips and (when LEADING_ZERO_BLANK_EN is defined) leading
// zero blanking.
module tb_seg_data_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  seg_sel;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        data_vld;
    logic [7:0]  seg_n;
    logic        pend;
    logic        frame_sot;

    int errors   = 0;
    int checks   = 0;
    int sotCount = 0;

    seg_data_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .seg_sel   (seg_sel),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .data_vld  (data_vld),
        .seg_n     (seg_n),
        .pend      (pend),
        .frame_sot (frame_sot)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_sot === 1'b1) begin
            sotCount = sotCount + 1;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h77;
            4'hB: return 7'h1F;
            4'hC: return 7'h4E;
            4'hD: return 7'h3D;
            4'hE: return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    function automatic logic [7:0] expSeg(input logic [3:0] n, input logic dp);
        return ~{glyph(n), dp};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Move the scanner to a digit and let the pipeline settle.
    task automatic applyStimulus(input logic [2:0] sel);
        @(negedge clk);
        seg_sel = sel;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic loadValue(input logic [31:0] d, input logic [7:0] dp);
        @(negedge clk);
        data_in  = d;
        dp_in    = dp;
        data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
    endtask

    task automatic scanFrame();
        for (int i = 1; i < 8; i++) applyStimulus(3'(i));
        applyStimulus(3'd0);
    endtask

    initial begin
        int  snap;
        bit  sawEight;
        logic [7:0] exp6;

        reset    = 1'b1;
        seg_sel  = 3'd0;
        data_in  = 32'h0;
        dp_in    = 8'h0;
        data_vld = 1'b0;
        #1 reset = 1'b0;
        #1;
        checkOutput("rst_seg", 32'(seg_n), 32'h0000_00FF);
        checkOutput("rst_pend", 32'(pend), 32'h0);
        checkOutput("rst_sot", 32'(frame_sot), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_zero", 32'(seg_n), 32'(expSeg(4'h0, 1'b0)));

        $display("[TB] basic load and latency");
        loadValue(32'h0123_4567, 8'h00);
        checkOutput("t2_pend_set", 32'(pend), 32'h1);
        snap = sotCount;
        for (int i = 1; i < 8; i++) applyStimulus(3'(i));
        checkOutput("t2_no_sot_early", 32'(sotCount - snap), 32'h0);
        applyStimulus(3'd0);
        checkOutput("t2_sot_once", 32'(sotCount - snap), 32'h1);
        checkOutput("t2_pend_clr", 32'(pend), 32'h0);
        checkOutput("t2_dig0", 32'(seg_n), 32'(expSeg(4'h7, 1'b0)));
        @(negedge clk);
        seg_sel = 3'd3;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t2_lat_early%0d", k), 32'(seg_n), 32'(expSeg(4'h7, 1'b0)));
        end
        @(posedge clk);
        #1;
        checkOutput("t2_lat4_dig3", 32'(seg_n), 32'(expSeg(4'h4, 1'b0)));

        $display("[TB] last strobe wins");
        loadValue(32'h1111_1111, 8'h00);
        loadValue(32'h2222_2222, 8'h00);
        for (int i = 4; i < 8; i++) applyStimulus(3'(i));
        checkOutput("t3_pend_hold", 32'(pend), 32'h1);
        checkOutput("t3_old_dig7", 32'(seg_n), 32'(expSeg(4'h0, 1'b0)));
        applyStimulus(3'd0);
        checkOutput("t3_pend_clr", 32'(pend), 32'h0);
        checkOutput("t3_dig0", 32'(seg_n), 32'(expSeg(4'h2, 1'b0)));
        for (int i = 1; i < 8; i++) begin
            applyStimulus(3'(i));
            checkOutput($sformatf("t3_dig%0d", i), 32'(seg_n), 32'(expSeg(4'h2, 1'b0)));
        end

        $display("[TB] strobe on boundary");
        loadValue(32'h3333_3333, 8'h00);
        snap = sotCount;
        @(negedge clk);
        seg_sel = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        data_in  = 32'h4444_4444;
        dp_in    = 8'h01;
        data_vld = 1'b1;
        @(negedge clk);
        data_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_sot", 32'(sotCount - snap), 32'h1);
        checkOutput("t4_pend_stays", 32'(pend), 32'h1);
        checkOutput("t4_old_shown", 32'(seg_n), 32'(expSeg(4'h3, 1'b0)));
        scanFrame();
        checkOutput("t4_new_shown", 32'(seg_n), 32'(expSeg(4'h4, 1'b1)));
        checkOutput("t4_pend_clr", 32'(pend), 32'h0);
        checkOutput("t4_sot_two", 32'(sotCount - snap), 32'h2);

        $display("[TB] skewed select");
        loadValue(32'h8765_4321, 8'h00);
        scanFrame();
        applyStimulus(3'd3);
        checkOutput("t5_dig3", 32'(seg_n), 32'(expSeg(4'h4, 1'b0)));
        snap = sotCount;
        sawEight = 1'b0;
        @(negedge clk);
        seg_sel = 3'b111;
        @(negedge clk);
        seg_sel = 3'b100;
        repeat (10) begin
            @(negedge clk);
            if (seg_n == expSeg(4'h8, 1'b0)) sawEight = 1'b1;
        end
        checkOutput("t5_never7", 32'(sawEight), 32'h0);
        checkOutput("t5_no_sot", 32'(sotCount - snap), 32'h0);
        checkOutput("t5_dig4", 32'(seg_n), 32'(expSeg(4'h5, 1'b0)));

        $display("[TB] skip to zero");
        loadValue(32'h0000_00A0, 8'h00);
        applyStimulus(3'd5);
        snap = sotCount;
        applyStimulus(3'd0);
        checkOutput("skip_no_sot", 32'(sotCount - snap), 32'h0);
        checkOutput("skip_pend", 32'(pend), 32'h1);
        checkOutput("skip_hold", 32'(seg_n), 32'(expSeg(4'h1, 1'b0)));
        scanFrame();
        checkOutput("skip_loaded", 32'(pend), 32'h0);

        $display("[TB] leading zeros");
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(3'(i));
            if (i == 1) exp6 = expSeg(4'hA, 1'b0);
            else if (i == 0) exp6 = expSeg(4'h0, 1'b0);
            else begin
`ifdef LEADING_ZERO_BLANK_EN
                exp6 = 8'hFF;
`else
                exp6 = expSeg(4'h0, 1'b0);
`endif
            end
            checkOutput($sformatf("t6_dig%0d", i), 32'(seg_n), 32'(exp6));
        end

        $display("[TB] reset mid-scan");
        loadValue(32'h0000_0005, 8'h00);
        applyStimulus(3'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_seg_off", 32'(seg_n), 32'h0000_00FF);
        checkOutput("t1_pend", 32'(pend), 32'h0);
        checkOutput("t1_sot", 32'(frame_sot), 32'h0);
        seg_sel = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t1_after_zero", 32'(seg_n), 32'(expSeg(4'h0, 1'b0)));
        checkOutput("t1_after_pend", 32'(pend), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
